// File: rtl/id_exe_pipe_reg.sv
// Elastic ID/EX pipeline register with valid/ready handshake, flush and a saturating stall counter.
// Define ID_EXE_SKID_EN to add a one-entry skid buffer so that in_ready comes straight from a flop.
module id_exe_pipe_reg #(
  parameter int DSIZE  = 32,
  parameter int ASIZE  = 5,
  parameter int ISIZE  = 32,
  parameter int CTRL_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DSIZE-1:0]  rdata1_in,
  input  logic [DSIZE-1:0]  rdata2_in,
  input  logic [DSIZE-1:0]  rdata2_imm_in,
  input  logic [DSIZE-1:0]  imm_in,
  input  logic [ASIZE-1:0]  waddr_in,
  input  logic [ISIZE-1:0]  npc_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  rdata1_out,
  output logic [DSIZE-1:0]  rdata2_out,
  output logic [DSIZE-1:0]  rdata2_imm_out,
  output logic [DSIZE-1:0]  imm_out,
  output logic [ASIZE-1:0]  waddr_out,
  output logic [ISIZE-1:0]  npc_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PAY_W = 4 * DSIZE + ASIZE + ISIZE;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_q, pay_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xfer_in;

  assign pay_in  = {rdata1_in, rdata2_in, rdata2_imm_in, imm_in, waddr_in, npc_in};
  assign xfer_in = in_valid & in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (vld_q && !out_ready && !flush) cnt_d = sat_inc(cnt_q);
  end

`ifdef ID_EXE_SKID_EN
  logic [PAY_W-1:0]  skid_pay_q, skid_pay_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              skid_vld_q, skid_vld_d;

  assign in_ready = ~skid_vld_q;

  always_comb begin
    vld_d       = vld_q;
    ctrl_d      = ctrl_q;
    pay_d       = pay_q;
    skid_vld_d  = skid_vld_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_pay_d  = skid_pay_q;
    if (flush) begin
      vld_d      = 1'b0;
      ctrl_d     = '0;
      skid_vld_d = 1'b0;
    end else if (vld_q && !out_ready) begin
      // Output is blocked: a newly accepted entry parks in the skid slot.
      if (xfer_in) begin
        skid_vld_d  = 1'b1;
        skid_ctrl_d = ctrl_in;
        skid_pay_d  = pay_in;
      end
    end else if (skid_vld_q) begin
      vld_d      = 1'b1;
      ctrl_d     = skid_ctrl_q;
      pay_d      = skid_pay_q;
      skid_vld_d = 1'b0;
    end else begin
      vld_d  = in_valid;
      ctrl_d = in_valid ? ctrl_in : '0;
      if (in_valid) pay_d = pay_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_q  <= 1'b0;
      skid_ctrl_q <= '0;
      skid_pay_q  <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_pay_q  <= skid_pay_d;
    end
  end
`else
  assign in_ready = out_ready | ~vld_q;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    pay_d  = pay_q;
    if (flush) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (in_ready) begin
      // Bubbles carry an all-zero control bundle so no side effects leak into execute.
      vld_d  = in_valid;
      ctrl_d = in_valid ? ctrl_in : '0;
      if (in_valid) pay_d = pay_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      pay_q  <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      pay_q  <= pay_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign ctrl_out  = ctrl_q;
  assign stall_cnt = cnt_q;
  assign {rdata1_out, rdata2_out, rdata2_imm_out, imm_out, waddr_out, npc_out} = pay_q;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Randomized bench for id_exe_pipe_reg against a queue-based occupancy model.
module tb_id_exe_pipe_reg;
  localparam int DSIZE = 32, ASIZE = 5, ISIZE = 32, CTRL_W = 7, CNT_W = 16, CNT_S = 4;

  typedef struct packed {
    logic [DSIZE-1:0]  r1;
    logic [DSIZE-1:0]  r2;
    logic [DSIZE-1:0]  r2i;
    logic [DSIZE-1:0]  imm;
    logic [ASIZE-1:0]  wa;
    logic [ISIZE-1:0]  npc;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, out_ready;
  logic [DSIZE-1:0] rdata1_in, rdata2_in, rdata2_imm_in, imm_in;
  logic [ASIZE-1:0] waddr_in;
  logic [ISIZE-1:0] npc_in;
  logic [CTRL_W-1:0] ctrl_in;

  logic in_ready, out_valid;
  logic [DSIZE-1:0] rdata1_out, rdata2_out, rdata2_imm_out, imm_out;
  logic [ASIZE-1:0] waddr_out;
  logic [ISIZE-1:0] npc_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [CNT_W-1:0] stall_cnt;

  logic s_in_ready, s_out_valid;
  logic [DSIZE-1:0] s_r1, s_r2, s_r2i, s_imm;
  logic [ASIZE-1:0] s_wa;
  logic [ISIZE-1:0] s_npc;
  logic [CTRL_W-1:0] s_ctrl;
  logic [CNT_S-1:0] s_cnt;

  id_exe_pipe_reg #(.DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .rdata2_imm_in(rdata2_imm_in), .imm_in(imm_in),
    .waddr_in(waddr_in), .npc_in(npc_in), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .rdata2_imm_out(rdata2_imm_out), .imm_out(imm_out),
    .waddr_out(waddr_out), .npc_out(npc_out), .ctrl_out(ctrl_out), .stall_cnt(stall_cnt)
  );

  id_exe_pipe_reg #(.DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE), .CTRL_W(CTRL_W), .CNT_W(CNT_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .rdata2_imm_in(rdata2_imm_in), .imm_in(imm_in),
    .waddr_in(waddr_in), .npc_in(npc_in), .ctrl_in(ctrl_in),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .rdata1_out(s_r1), .rdata2_out(s_r2), .rdata2_imm_out(s_r2i), .imm_out(s_imm),
    .waddr_out(s_wa), .npc_out(s_npc), .ctrl_out(s_ctrl), .stall_cnt(s_cnt)
  );

`ifdef ID_EXE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  ent_t q[$];
  int   cnt_big, cnt_small;
  int   nvec = 0, nerr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    if (!rst_n) return 1'b1;
    if (DEPTH == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.r1   = $urandom;
    e.r2   = $urandom;
    e.r2i  = $urandom;
    e.imm  = $urandom;
    e.wa   = ASIZE'($urandom);
    e.npc  = $urandom;
    e.ctrl = CTRL_W'($urandom);
    return e;
  endfunction

  task automatic check_all();
    bit v;
    v = q.size() > 0;
    check("in_ready", 64'(in_ready), 64'(exp_ready()));
    check("out_valid", 64'(out_valid), 64'(v));
    check("ctrl_out", 64'(ctrl_out), v ? 64'(q[0].ctrl) : 64'd0);
    check("stall_cnt", 64'(stall_cnt), 64'(cnt_big));
    check("stall_cnt_s", 64'(s_cnt), 64'(cnt_small));
    check("s_out_valid", 64'(s_out_valid), 64'(v));
    if (v) begin
      check("rdata1_out", 64'(rdata1_out), 64'(q[0].r1));
      check("rdata2_out", 64'(rdata2_out), 64'(q[0].r2));
      check("rdata2_imm_out", 64'(rdata2_imm_out), 64'(q[0].r2i));
      check("imm_out", 64'(imm_out), 64'(q[0].imm));
      check("waddr_out", 64'(waddr_out), 64'(q[0].wa));
      check("npc_out", 64'(npc_out), 64'(q[0].npc));
    end
  endtask

  // Drive one cycle of inputs, check, then advance the model across the rising edge.
  task automatic step(input bit iv, input bit ordy, input bit fl, input ent_t e);
    bit rdy, popv, stall;
    in_valid = iv; out_ready = ordy; flush = fl;
    rdata1_in = e.r1; rdata2_in = e.r2; rdata2_imm_in = e.r2i; imm_in = e.imm;
    waddr_in = e.wa; npc_in = e.npc; ctrl_in = e.ctrl;
    #1;
    check_all();
    rdy   = exp_ready();
    popv  = (q.size() > 0) && ordy;
    stall = (q.size() > 0) && !ordy && !fl;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); cnt_big = 0; cnt_small = 0;
    end else begin
      if (fl) q.delete();
      else begin
        if (popv) void'(q.pop_front());
        if (iv && rdy) q.push_back(e);
      end
      if (stall) begin
        if (cnt_big < (1 << CNT_W) - 1) cnt_big++;
        if (cnt_small < (1 << CNT_S) - 1) cnt_small++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    ent_t e;
    int   c0;
    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
    rdata1_in = '0; rdata2_in = '0; rdata2_imm_in = '0; imm_in = '0;
    waddr_in = '0; npc_in = '0; ctrl_in = '0;
    cnt_big = 0; cnt_small = 0;
    #2;
    check("rst_rdata1_out", 64'(rdata1_out), 64'd0);
    check("rst_npc_out", 64'(npc_out), 64'd0);
    check("rst_waddr_out", 64'(waddr_out), 64'd0);
    e = rnd_ent();
    repeat (3) step(1, 1, 0, e);
    rst_n = 1'b1;

    // Streaming 0x11, 0x22, 0x33.
    for (int i = 1; i <= 3; i++) begin
      e = rnd_ent(); e.r1 = 32'(i * 'h11);
      step(1, 1, 0, e);
    end
    step(0, 1, 0, rnd_ent());
    check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

    // Backpressure: 0xAA held for 4 cycles while 0xBB is offered.
    e = rnd_ent(); e.r1 = 32'hAA; step(1, 1, 0, e);
    e = rnd_ent(); e.r1 = 32'hBB;
    repeat (4) step(1, 0, 0, e);
    check("bp_stall_cnt", 64'(stall_cnt), 64'd4);
    check("bp_rdata1_hold", 64'(rdata1_out), 64'hAA);
    repeat (3) step(0, 1, 0, rnd_ent());

    // Flush of a held wen/branch entry while a new valid entry is offered.
    e = rnd_ent(); e.ctrl = 7'h48; step(1, 1, 0, e);
    step(1, 0, 0, rnd_ent());
    step(1, 0, 1, rnd_ent());
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl_out", 64'(ctrl_out), 64'd0);
    step(0, 1, 0, rnd_ent());

    // Bubble carries no control.
    e = rnd_ent(); e.ctrl = 7'h7F; step(0, 1, 0, e);
    check("bubble_ctrl_out", 64'(ctrl_out), 64'd0);

    // Saturation of the 4-bit counter.
    step(1, 1, 0, rnd_ent());
    c0 = cnt_big;
    repeat (20) step(0, 0, 0, rnd_ent());
    check("sat_small", 64'(s_cnt), 64'd15);
    check("sat_big", 64'(stall_cnt), 64'(c0 + 20));

    // Asynchronous reset mid-stall, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_ctrl_out", 64'(ctrl_out), 64'd0);
    check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("arst_stall_cnt_s", 64'(s_cnt), 64'd0);
    q.delete(); cnt_big = 0; cnt_small = 0;
    @(negedge clk);
    step(1, 0, 0, rnd_ent());
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0), rnd_ent());
    end
    step(0, 1, 0, rnd_ent());

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
